// File: rtl/mem_responder_pkg.sv
// Shared definitions for the CPU memory bus: responder FSM encoding and
// the ROM/RAM space-select values driven on rom_ram.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROG  = 2'd1,
    ADDR  = 2'd2,
    WDATA = 2'd3
  } mem_state_e;

  localparam logic SPACE_ROM = 1'b0;
  localparam logic SPACE_RAM = 1'b1;

  function automatic int addr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_responder_ram_bank.sv
// Byte-wide RAM used for the responder's RAM space: synchronous write,
// registered read that only updates on a read request, async clear.
module ram_bank
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // rdata holds between reads so the CPU sees a stable value across write phases
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      rdata <= 8'h00;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      if (re) begin
        rdata <= mem[raddr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the lab CPU: decodes address/write-data phases into a
// programmable ROM and a small RAM, returning read data one cycle later.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ROM_DEPTH = 256,
  parameter int RAM_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bus_in,
  input  logic       rom_ram,
  input  logic       addr_data,
  output logic [7:0] bus_out,
  input  logic       prog_en,
  input  logic [7:0] prog_addr,
  input  logic [7:0] prog_data,
  output logic       bus_err
);

  localparam int ROM_AW = addr_width(ROM_DEPTH);
  localparam int RAM_AW = addr_width(RAM_DEPTH);

  mem_state_e state, next_state;
  logic       addr_phase;
  logic       data_phase;
  logic       prog_wr;

  logic [7:0] addr_reg;
  logic       space_reg;
  logic       out_clr;
  logic [7:0] rom [ROM_DEPTH];
  logic [7:0] rom_rdata;
  logic [7:0] ram_rdata;
  logic       ram_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // prog_en wins over any bus phase presented in the same cycle
  always_comb begin
    next_state = state;
    addr_phase = 1'b0;
    data_phase = 1'b0;
    prog_wr    = 1'b0;
    if (state == PROG) begin
      prog_wr = 1'b1;
      if (!prog_en) begin
        next_state = IDLE;
      end
    end else if (prog_en) begin
      next_state = PROG;
    end else if (!addr_data) begin
      addr_phase = 1'b1;
      next_state = ADDR;
    end else begin
      data_phase = 1'b1;
      next_state = WDATA;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg  <= 8'h00;
      space_reg <= SPACE_ROM;
      bus_err   <= 1'b0;
      out_clr   <= 1'b1;
    end else begin
      if (addr_phase) begin
        addr_reg  <= bus_in;
        space_reg <= rom_ram;
      end
      if (data_phase && (space_reg == SPACE_ROM)) begin
        bus_err <= 1'b1;
      end
      // out_clr blanks bus_out from the first PROG cycle until a fresh read lands
      if (next_state == PROG) begin
        out_clr <= 1'b1;
      end else if (addr_phase) begin
        out_clr <= 1'b0;
      end
    end
  end

  // ROM survives reset so programmed contents outlive a CPU restart
  always_ff @(posedge clk) begin
    if (prog_wr && (int'(prog_addr) < ROM_DEPTH)) begin
      rom[prog_addr[ROM_AW-1:0]] <= prog_data;
    end
  end

  assign rom_rdata = (int'(addr_reg) < ROM_DEPTH) ? rom[addr_reg[ROM_AW-1:0]] : 8'h00;

  assign ram_we = data_phase && (space_reg == SPACE_RAM);

  ram_bank #(
    .DEPTH (RAM_DEPTH),
    .AW    (RAM_AW)
  ) u_ram_bank (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .waddr (addr_reg[RAM_AW-1:0]),
    .wdata (bus_in),
    .re    (addr_phase),
    .raddr (bus_in[RAM_AW-1:0]),
    .rdata (ram_rdata)
  );

  assign bus_out = out_clr ? 8'h00 :
                   (space_reg == SPACE_RAM) ? ram_rdata : rom_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a small ROM to exercise the
// out-of-range boundary; a behavioural model is compared every cycle.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int ROM_D = 64;
  localparam int RAM_D = 16;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] bus_in    = 8'h00;
  logic       rom_ram   = 1'b0;
  logic       addr_data = 1'b0;
  logic       prog_en   = 1'b0;
  logic [7:0] prog_addr = 8'h00;
  logic [7:0] prog_data = 8'h00;
  logic [7:0] bus_out;
  logic       bus_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  bit         in_prog    = 1'b0;
  logic [7:0] exp_out    = 8'h00;
  logic       exp_err    = 1'b0;
  logic [7:0] last_addr  = 8'h00;
  logic       last_space = 1'b0;
  logic [7:0] rom_m [256];
  logic [7:0] ram_m [RAM_D];

  mem_responder #(
    .ROM_DEPTH (ROM_D),
    .RAM_DEPTH (RAM_D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_in    (bus_in),
    .rom_ram   (rom_ram),
    .addr_data (addr_data),
    .bus_out   (bus_out),
    .prog_en   (prog_en),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] romPattern(input int i);
    case (i)
      0:       return 8'h11;
      1:       return 8'h22;
      2:       return 8'h33;
      5:       return 8'hA7;
      default: return 8'(i) ^ 8'hC3;
    endcase
  endfunction

  function automatic logic [7:0] modelRom(input logic [7:0] a);
    return (int'(a) < ROM_D) ? rom_m[a] : 8'h00;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic pe, input logic [7:0] pa, input logic [7:0] pd,
                               input logic [7:0] bi, input logic rr, input logic ad);
    prog_en   = pe;
    prog_addr = pa;
    prog_data = pd;
    bus_in    = bi;
    rom_ram   = rr;
    addr_data = ad;
    @(posedge clk);
    #1;
  endtask

  task automatic addrPhase(input logic [7:0] a, input logic sp);
    applyStimulus(1'b0, 8'h00, 8'h00, a, sp, 1'b0);
  endtask

  task automatic dataPhase(input logic [7:0] d);
    applyStimulus(1'b0, 8'h00, 8'h00, d, 1'b0, 1'b1);
  endtask

  task automatic progCycle(input logic [7:0] a, input logic [7:0] d);
    applyStimulus(1'b1, a, d, 8'h00, 1'b0, 1'b0);
  endtask

  // Reference behaviour: what the CPU should observe, from the bus rules alone
  initial begin
    for (int i = 0; i < 256; i++) rom_m[i] = 8'h00;
    for (int i = 0; i < RAM_D; i++) ram_m[i] = 8'h00;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        in_prog    = 1'b0;
        exp_out    = 8'h00;
        exp_err    = 1'b0;
        last_addr  = 8'h00;
        last_space = SPACE_ROM;
        for (int i = 0; i < RAM_D; i++) ram_m[i] = 8'h00;
      end else if (in_prog) begin
        if (int'(prog_addr) < ROM_D) rom_m[prog_addr] = prog_data;
        exp_out = 8'h00;
        if (!prog_en) in_prog = 1'b0;
      end else if (prog_en) begin
        in_prog = 1'b1;
        exp_out = 8'h00;
      end else if (!addr_data) begin
        last_addr  = bus_in;
        last_space = rom_ram;
        exp_out    = rom_ram ? ram_m[int'(bus_in) % RAM_D] : modelRom(bus_in);
      end else if (last_space == SPACE_RAM) begin
        ram_m[int'(last_addr) % RAM_D] = bus_in;
      end else begin
        exp_err = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        checkOutput("model bus_out", bus_out, exp_out);
        checkOutput("model bus_err", {7'b0, bus_err}, {7'b0, exp_err});
      end
    end
  end

  initial begin
    #1 reset = 1'b0;
    #3;
    check_en = 1'b1;
    checkOutput("reset bus_out", bus_out, 8'h00);
    checkOutput("reset bus_err", {7'b0, bus_err}, 8'h00);
    @(posedge clk);
    #1 reset = 1'b1;

    progCycle(8'h00, 8'h00);
    for (int i = 0; i < 256; i++) progCycle(8'(i), romPattern(i));
    checkOutput("prog bus_out", bus_out, 8'h00);
    applyStimulus(1'b0, 8'hFF, romPattern(255), 8'h00, 1'b0, 1'b0);
    checkOutput("prog exit bus_out", bus_out, 8'h00);

    addrPhase(8'h05, SPACE_ROM);  checkOutput("rom 05", bus_out, 8'hA7);
    addrPhase(8'h00, SPACE_ROM);  checkOutput("b2b 00", bus_out, 8'h11);
    addrPhase(8'h01, SPACE_ROM);  checkOutput("b2b 01", bus_out, 8'h22);
    addrPhase(8'h02, SPACE_ROM);  checkOutput("b2b 02", bus_out, 8'h33);
    addrPhase(8'h3F, SPACE_ROM);  checkOutput("rom last", bus_out, 8'hFC);
    addrPhase(8'h40, SPACE_ROM);  checkOutput("rom beyond", bus_out, 8'h00);

    addrPhase(8'h03, SPACE_RAM);  checkOutput("ram 03 clear", bus_out, 8'h00);
    dataPhase(8'h5C);             checkOutput("ram write hold", bus_out, 8'h00);
    addrPhase(8'h03, SPACE_RAM);  checkOutput("ram 03", bus_out, 8'h5C);
    addrPhase(8'h13, SPACE_RAM);  checkOutput("ram 13 wrap", bus_out, 8'h5C);
    checkOutput("ram no err", {7'b0, bus_err}, 8'h00);
    dataPhase(8'h77);             checkOutput("wrap write hold", bus_out, 8'h5C);
    addrPhase(8'h03, SPACE_RAM);  checkOutput("ram 03 rewrite", bus_out, 8'h77);

    addrPhase(8'h10, SPACE_ROM);  checkOutput("rom 10", bus_out, 8'hD3);
    dataPhase(8'hFF);
    checkOutput("rom write err", {7'b0, bus_err}, 8'h01);
    checkOutput("rom write hold", bus_out, 8'hD3);
    addrPhase(8'h10, SPACE_ROM);  checkOutput("rom 10 intact", bus_out, 8'hD3);
    addrPhase(8'h03, SPACE_RAM);  checkOutput("err sticky", {7'b0, bus_err}, 8'h01);

    addrPhase(8'h05, SPACE_ROM);  checkOutput("pre-abort", bus_out, 8'hA7);
    progCycle(8'h20, 8'h99);      checkOutput("abort bus_out", bus_out, 8'h00);
    progCycle(8'h20, 8'h99);
    applyStimulus(1'b0, 8'h20, 8'h99, 8'h00, 1'b0, 1'b0);
    checkOutput("abort exit", bus_out, 8'h00);
    checkOutput("err through prog", {7'b0, bus_err}, 8'h01);
    addrPhase(8'h20, SPACE_ROM);  checkOutput("rom 20 reprog", bus_out, 8'h99);

    addrPhase(8'h07, SPACE_RAM);  checkOutput("ram 07", bus_out, 8'h00);
    dataPhase(8'h42);
    #2 reset = 1'b0;
    #1;
    checkOutput("wdata reset bus_out", bus_out, 8'h00);
    checkOutput("wdata reset bus_err", {7'b0, bus_err}, 8'h00);
    @(posedge clk);
    #1 reset = 1'b1;
    addrPhase(8'h07, SPACE_RAM);  checkOutput("ram 07 cleared", bus_out, 8'h00);
    addrPhase(8'h03, SPACE_RAM);  checkOutput("ram 03 cleared", bus_out, 8'h00);
    addrPhase(8'h05, SPACE_ROM);  checkOutput("rom 05 kept", bus_out, 8'hA7);
    addrPhase(8'h20, SPACE_ROM);  checkOutput("rom 20 kept", bus_out, 8'h99);

    progCycle(8'h30, 8'h5A);
    progCycle(8'h30, 8'h5A);
    #2;
    prog_en = 1'b0;
    reset   = 1'b0;
    #1;
    checkOutput("prog reset bus_out", bus_out, 8'h00);
    @(posedge clk);
    #1 reset = 1'b1;
    addrPhase(8'h30, SPACE_ROM);  checkOutput("rom 30 kept", bus_out, 8'h5A);
    addrPhase(8'h31, SPACE_ROM);  checkOutput("rom 31", bus_out, 8'hF2);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
